// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory request/response bus
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit with single outstanding request and small FIFO
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           instruction_out,
    output logic [31:0]           pc_out,
    output logic                  valid_out,
    output logic                  flush_out
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   fpc;
    logic          req_q;
    logic [31:0]   addr_q;
    logic          flush_q;

    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          has_room;
    logic          issue;
    logic          push;
    logic          pop;
    logic          ack_taken;
    logic [PW-1:0] rd_ptr_inc;
    logic [PW-1:0] wr_ptr_inc;

    // Only one request is ever in flight, and only from IDLE, so outstanding is zero here.
    assign has_room   = (count < CW'(BUF_DEPTH));
    assign valid_out  = (count != '0);
    assign rd_ptr_inc = (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    assign wr_ptr_inc = (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!redirect && has_room) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem.ack) begin
                    state_next = IDLE;
                end else if (redirect) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem.ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue     = 1'b0;
        push      = 1'b0;
        ack_taken = 1'b0;
        case (state)
            IDLE: issue = !redirect && has_room;
            REQ: begin
                ack_taken = imem.ack;
                push      = imem.ack && !redirect;
            end
            DRAIN: ack_taken = imem.ack;
            default: begin
                issue     = 1'b0;
                push      = 1'b0;
                ack_taken = 1'b0;
            end
        endcase
        pop = valid_out && !stall && !redirect;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc     <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= 32'h0;
            flush_q <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            flush_q <= redirect;

            if (redirect) begin
                fpc <= redirect_pc;
            end else if (issue) begin
                fpc <= fpc + 32'd4;
            end

            if (issue) begin
                req_q  <= 1'b1;
                addr_q <= fpc;
            end else if (ack_taken) begin
                req_q  <= 1'b0;
            end

            // A redirect discards everything queued, including a same-cycle response.
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr_inc;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr_inc;
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_pc[wr_ptr]    <= addr_q;
            buf_instr[wr_ptr] <= imem.data;
        end
    end

    assign imem.req        = req_q;
    assign imem.addr       = addr_q;
    assign flush_out       = flush_q;
    assign instruction_out = valid_out ? buf_instr[rd_ptr] : 32'h0;
    assign pc_out          = valid_out ? buf_pc[rd_ptr]    : 32'h0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        flush_out;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (bus),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out),
        .flush_out       (flush_out)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    int          mem_lat = 1;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;
    logic        prev_req = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        force_ack   = 1'b0;
        tick(2);
        exp_addr_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic end_phase(input string name);
        check({name, "_addr_drained"}, 32'(exp_addr_q.size()), 32'h0);
        check({name, "_pc_drained"}, 32'(exp_pc_q.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req"},   32'(bus.req),   32'h0);
        check({name, "_addr"},  bus.addr,       32'h0);
        check({name, "_valid"}, 32'(valid_out), 32'h0);
        check({name, "_instr"}, instruction_out, 32'h0);
        check({name, "_pc"},    pc_out,         32'h0);
        check({name, "_flush"}, 32'(flush_out), 32'h0);
    endtask

    initial begin
        bus.ack  = 1'b0;
        bus.data = 32'h0;
    end

    // Memory model: acks after mem_lat cycles of visible request, plus an injectable stray ack.
    always @(negedge clock) begin
        if (force_ack) begin
            bus.ack  = 1'b1;
            bus.data = 32'hDEAD_BEEF;
            wait_cnt = 0;
        end else if (bus.ack) begin
            bus.ack  = 1'b0;
            wait_cnt = 0;
        end else if (bus.req && !reset) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                bus.ack  = 1'b1;
                bus.data = mem_word(bus.addr);
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clock) begin : monitor
        logic [31:0] e;
        if (bus.req && !prev_req && exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            check("imem_addr", bus.addr, e);
        end
        prev_req = bus.req;
        if (!reset && valid_out && !stall && !redirect && exp_pc_q.size() > 0) begin
            e = exp_pc_q.pop_front();
            check("pc_out", pc_out, e);
            check("instruction_out", instruction_out, mem_word(e));
        end
    end

    initial begin
        // Straight-line fetch, latency 1
        do_reset();
        check_reset_outputs("reset");
        exp_addr_q = {32'h0, 32'h4, 32'h8, 32'hC};
        exp_pc_q   = {32'h0, 32'h4, 32'h8};
        reset = 1'b0;
        tick(1);
        check("first_req", 32'(bus.req), 32'h1);
        check("first_addr", bus.addr, 32'h0);
        tick(11);
        end_phase("seq");

        // Stall fills the buffer, then drains in order
        do_reset();
        stall = 1'b1;
        exp_addr_q = {32'h0, 32'h4, 32'h8};
        exp_pc_q   = {32'h0, 32'h4, 32'h8};
        reset = 1'b0;
        tick(8);
        check("stall_valid", 32'(valid_out), 32'h1);
        check("stall_pc", pc_out, 32'h0);
        check("stall_instr", instruction_out, mem_word(32'h0));
        check("stall_no_req", 32'(bus.req), 32'h0);
        stall = 1'b0;
        tick(10);
        end_phase("stall");

        // Redirect while a slow request is outstanding
        do_reset();
        mem_lat = 4;
        exp_addr_q = {32'h10, 32'h200, 32'h204};
        exp_pc_q   = {32'h200, 32'h204};
        reset = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h10;
        tick(1);
        redirect = 1'b0;
        check("drain_flush0", 32'(flush_out), 32'h1);
        check("drain_noreq", 32'(bus.req), 32'h0);
        tick(1);
        check("drain_flush0_end", 32'(flush_out), 32'h0);
        check("drain_req10", 32'(bus.req), 32'h1);
        tick(1);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick(1);
        redirect = 1'b0;
        check("drain_flush1", 32'(flush_out), 32'h1);
        check("drain_hold_addr", bus.addr, 32'h10);
        check("drain_hold_req", 32'(bus.req), 32'h1);
        check("drain_valid", 32'(valid_out), 32'h0);
        tick(1);
        check("drain_flush1_end", 32'(flush_out), 32'h0);
        check("drain_hold_addr2", bus.addr, 32'h10);
        tick(18);
        end_phase("drain");
        mem_lat = 1;

        // Redirect coincident with the ack for 0x8
        do_reset();
        exp_addr_q = {32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
        exp_pc_q   = {32'h0, 32'h4, 32'h40};
        reset = 1'b0;
        tick(5);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick(1);
        redirect = 1'b0;
        check("coinc_flush", 32'(flush_out), 32'h1);
        check("coinc_valid", 32'(valid_out), 32'h0);
        check("coinc_req", 32'(bus.req), 32'h0);
        tick(10);
        end_phase("coinc");

        // Address wrap at the top of memory
        do_reset();
        exp_addr_q = {32'hFFFF_FFFC, 32'h0, 32'h4};
        exp_pc_q   = {32'hFFFF_FFFC, 32'h0, 32'h4};
        reset = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        tick(12);
        end_phase("wrap");

        // Redirect overrides stall and clears a full buffer
        do_reset();
        stall = 1'b1;
        exp_addr_q = {32'h0, 32'h4, 32'h100, 32'h104};
        exp_pc_q   = {32'h100, 32'h104};
        reset = 1'b0;
        tick(8);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick(1);
        redirect = 1'b0;
        check("stallredir_valid", 32'(valid_out), 32'h0);
        check("stallredir_flush", 32'(flush_out), 32'h1);
        tick(1);
        check("stallredir_req", 32'(bus.req), 32'h1);
        check("stallredir_addr", bus.addr, 32'h100);
        stall = 1'b0;
        tick(10);
        end_phase("stallredir");

        // Reset mid-request, stray ack afterwards
        do_reset();
        mem_lat = 3;
        exp_addr_q = {32'h0, 32'h0, 32'h4};
        exp_pc_q   = {32'h0, 32'h4};
        reset = 1'b0;
        tick(1);
        check("midreset_req", 32'(bus.req), 32'h1);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        reset = 1'b0;
        force_ack = 1'b1;
        mem_lat = 1;
        tick(1);
        force_ack = 1'b0;
        check("stray_ack_valid", 32'(valid_out), 32'h0);
        check("restart_req", 32'(bus.req), 32'h1);
        check("restart_addr", bus.addr, 32'h0);
        tick(12);
        end_phase("midreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fetch buffer entries; only value 2 is required.
REQ-003 Clock  input  1  sole clock; all state updates on posedge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  downstream IF/ID register not accepting; head entry held.
REQ-006 Redirect  input  1  one-cycle branch/jump taken pulse.
REQ-007 Redirect_PC  input  32  target address, valid when Redirect=1.
REQ-008 IMem_Req  output  1  instruction memory request, registered.
REQ-009 IMem_Addr  output  32  request word address, registered.
REQ-010 IMem_Ack  input  1  one-cycle response strobe, variable latency >=1 cycle.
REQ-011 IMem_Data  input  32  instruction word, valid when IMem_Ack=1.
REQ-012 Instruction_Out  output  32  head instruction, drives IF/ID Instruction_In.
REQ-013 PC_Out  output  32  address of head instruction, drives IF/ID PC_In.
REQ-014 Valid_Out  output  1  head entry present.
REQ-015 Flush_Out  output  1  registered pulse, drives IF/ID Flush.

Function
REQ-016 SHALL keep fetch PC register FPC; FPC+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) on each issued request.
REQ-017 SHALL implement FSM states IDLE, REQ, DRAIN.
REQ-018 IDLE: issue request (IMem_Req=1, IMem_Addr=FPC, next state REQ) when buffer count + outstanding < BUF_DEPTH and Redirect=0.
REQ-019 REQ: IMem_Req and IMem_Addr SHALL stay constant until IMem_Ack sampled high; then IMem_Req drops for at least one cycle; state -> IDLE.
REQ-020 IMem_Ack in REQ SHALL push {IMem_Addr, IMem_Data} into buffer tail.
REQ-021 IMem_Ack while IMem_Req=0 SHALL be ignored.
REQ-022 At most one request outstanding at any time.
REQ-023 Buffer SHALL be FIFO; head drives Instruction_Out/PC_Out; Valid_Out=1 iff buffer non-empty.
REQ-024 Buffer empty: Instruction_Out=32'h0 (NOP), PC_Out=32'h0, Valid_Out=0.
REQ-025 Pop SHALL occur on posedge when Valid_Out=1 and Stall=0; Stall=1 holds all three outputs unchanged.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 Overflow SHALL be impossible by REQ-018 gating; full buffer blocks new requests only.
REQ-028 Redirect in IDLE: FPC<=Redirect_PC, buffer cleared, no request that cycle; request to Redirect_PC issued next cycle.
REQ-029 Redirect in REQ without same-cycle Ack: FPC<=Redirect_PC, buffer cleared, state -> DRAIN; IMem_Req held until Ack.
REQ-030 Redirect in REQ with same-cycle Ack: response discarded (not pushed), buffer cleared, state -> IDLE.
REQ-031 DRAIN: Ack discards IMem_Data, state -> IDLE; further Redirect in DRAIN updates FPC only, stays DRAIN.
REQ-032 Redirect with Stall=1 SHALL still clear buffer; Redirect overrides Stall.
REQ-033 Flush_Out SHALL be 1 for exactly the cycle after any cycle with Redirect=1, else 0; back-to-back Redirects give back-to-back pulses.
REQ-034 Redirect_PC low two bits SHALL be used as given (no alignment enforcement).

Reset
REQ-035 Reset=1 at posedge: FPC=RESET_PC, buffer empty, state IDLE, IMem_Req=0, IMem_Addr=0, Valid_Out=0, Instruction_Out=0, PC_Out=0, Flush_Out=0.
REQ-036 Reset SHALL override Redirect, Stall, IMem_Ack; reset mid-REQ abandons request, later Ack ignored per REQ-021.
REQ-037 First request SHALL issue on first posedge with Reset=0 (IMem_Req=1 in following cycle).

Verification
REQ-038 Reset release, Ack latency 1, Stall=0 -> IMem_Addr 0,4,8,...; Valid_Out stream PC_Out 0,4,8 with matching IMem_Data.
REQ-039 Stall=1 for 5 cycles, Ack latency 1 -> buffer fills to 2, IMem_Req stays 0, outputs hold PC_Out=0; release -> PC 4,8 emitted in order, no loss.
REQ-040 Request to 32'h10 outstanding, Redirect_PC=32'h200 before Ack (latency 4) -> DRAIN, data for 0x10 discarded, next IMem_Addr=32'h200, Flush_Out one-cycle pulse, next valid PC_Out=32'h200.
REQ-041 Redirect coincident with Ack for 32'h8 -> 0x8 never on Valid_Out; next request 32'h40 (Redirect_PC).
REQ-042 Redirect_PC=32'hFFFF_FFFC -> fetches 32'hFFFF_FFFC then 32'h0.
REQ-043 Reset asserted while REQ outstanding, Ack one cycle later -> all outputs at reset values, Ack ignored, fetch restarts at RESET_PC.
